// File: rtl/ssf_io_pkg.sv
// rtl/ssf_io_pkg.sv - shared constants and helpers for the ssf I/O bridge
package ssf_io_pkg;
  localparam int NUBITS_DEF = 32;
  localparam int FDEPTH_DEF = 8;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Isolate the lowest set bit, giving a one-hot priority pick.
  function automatic logic [31:0] lowest_set(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction
endpackage

// File: rtl/ssf_io_bridge_if.sv
// rtl/ssf_io_bridge_if.sv - core port and stream bundle; SSF_IO_BRIDGE_COUNT_EN adds xfer_cnt
interface ssf_io_bridge_if import ssf_io_pkg::*; #(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2
);
  logic signed [NUBITS-1:0]        io_in;
  logic [NUIOIN-1:0]               req_in;
  logic signed [NUBITS-1:0]        io_out;
  logic [NUIOOU-1:0]               out_en;
  logic [NUIOIN*NUBITS-1:0]        s_data;
  logic [NUIOIN-1:0]               s_valid;
  logic [NUIOIN-1:0]               s_ready;
  logic [NUIOOU*NUBITS-1:0]        m_data;
  logic [NUIOOU-1:0]               m_valid;
  logic [NUIOOU-1:0]               m_ready;
  logic [NUIOIN-1:0]               underflow;
  logic [NUIOOU-1:0]               overflow;
`ifdef SSF_IO_BRIDGE_COUNT_EN
  logic [(NUIOIN+NUIOOU)*16-1:0]   xfer_cnt;
`endif

  modport slave (
`ifdef SSF_IO_BRIDGE_COUNT_EN
    output xfer_cnt,
`endif
    output io_in, s_ready, m_data, m_valid, underflow, overflow,
    input  req_in, io_out, out_en, s_data, s_valid, m_ready
  );

  modport master (
`ifdef SSF_IO_BRIDGE_COUNT_EN
    input  xfer_cnt,
`endif
    input  io_in, s_ready, m_data, m_valid, underflow, overflow,
    output req_in, io_out, out_en, s_data, s_valid, m_ready
  );
endinterface

// File: rtl/ssf_sync_fifo.sv
// rtl/ssf_sync_fifo.sv - single-clock FIFO with optional push-through-when-full-on-pop
module ssf_sync_fifo import ssf_io_pkg::*; #(
  parameter int NUBITS = NUBITS_DEF,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NUBITS-1:0] push_data,
  input  logic              pop,
  input  logic              force_push_on_pop,
  output logic [NUBITS-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = clog2(FDEPTH);
  localparam int CW = AW + 1;

  logic [NUBITS-1:0] mem [FDEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push, do_pop;

  assign full    = (count == CW'(FDEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO only takes a word when the caller opts in and a pop frees the slot this edge.
  assign do_push = push & (~full | (force_push_on_pop & do_pop));
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FDEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents are not cleared, the pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ssf_io_bridge.sv
// rtl/ssf_io_bridge.sv - proc_fx I/O responder with per-channel FIFOs; SSF_IO_BRIDGE_COUNT_EN adds transfer counters
module ssf_io_bridge import ssf_io_pkg::*; #(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input logic             clk,
  input logic             rst,
  ssf_io_bridge_if.slave  bus
);
  logic [NUIOIN-1:0] sel, in_full, in_empty, in_pop;
  logic [NUBITS-1:0] in_head [NUIOIN];
  logic [NUBITS-1:0] hold_q  [NUIOIN];
  logic [NUIOIN-1:0] udf_q;
  logic [NUBITS-1:0] io_in_c;

  logic [NUIOOU-1:0] out_full, out_empty, out_ok;
  logic [NUBITS-1:0] out_head [NUIOOU];
  logic [NUIOOU-1:0] ovf_q;

  // Only the lowest requested channel is served; other request bits are ignored.
  assign sel    = NUIOIN'(lowest_set(32'(bus.req_in)));
  assign in_pop = sel & ~in_empty;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    ssf_sync_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(bus.s_valid[k]), .push_data(bus.s_data[k*NUBITS +: NUBITS]),
      .pop(in_pop[k]), .force_push_on_pop(1'b0),
      .head(in_head[k]), .full(in_full[k]), .empty(in_empty[k])
    );
  end

  assign bus.s_ready   = rst ? '0 : ~in_full;
  assign bus.io_in     = io_in_c;
  assign bus.underflow = udf_q;

  // Core input mux: the core cannot stall, so an empty channel replays its last delivered word.
  always_comb begin
    io_in_c = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (sel[k]) io_in_c = in_empty[k] ? hold_q[k] : in_head[k];
    end
  end

  // Hold registers remember each channel's last popped word; underflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUIOIN; k++) hold_q[k] <= '0;
      udf_q <= '0;
    end else begin
      for (int k = 0; k < NUIOIN; k++) begin
        if (in_pop[k]) hold_q[k] <= in_head[k];
        if (sel[k] && in_empty[k]) udf_q[k] <= 1'b1;
      end
    end
  end

  // Every flagged output channel captures the same core word.
  for (genvar k = 0; k < NUIOOU; k++) begin : g_out
    ssf_sync_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(bus.out_en[k]), .push_data(bus.io_out),
      .pop(bus.m_ready[k]), .force_push_on_pop(1'b1),
      .head(out_head[k]), .full(out_full[k]), .empty(out_empty[k])
    );
    assign bus.m_valid[k]                   = ~out_empty[k];
    assign bus.m_data[k*NUBITS +: NUBITS]   = out_empty[k] ? '0 : out_head[k];
  end

  // A full channel still accepts when the sink drains it in the same cycle.
  assign out_ok       = bus.out_en & (~out_full | bus.m_ready);
  assign bus.overflow = ovf_q;

  // Sticky overflow on dropped core writes.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_q | (bus.out_en & ~out_ok);
  end

`ifdef SSF_IO_BRIDGE_COUNT_EN
  logic [15:0] cnt_q [NUIOIN+NUIOOU];

  // Wrapping per-channel counts of served reads and accepted writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUIOIN + NUIOOU; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUIOIN; i++) if (in_pop[i]) cnt_q[i] <= cnt_q[i] + 16'd1;
      for (int j = 0; j < NUIOOU; j++) if (out_ok[j]) cnt_q[NUIOIN+j] <= cnt_q[NUIOIN+j] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUIOIN + NUIOOU; i++) begin : g_cnt
    assign bus.xfer_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif
endmodule

// File: tb/tb_ssf_io_bridge.sv
// tb/tb_ssf_io_bridge.sv - directed and randomized checks of ssf_io_bridge against a queue model
module tb_ssf_io_bridge;
  localparam int NB = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssf_io_bridge_if #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO)) bus ();
  ssf_io_bridge #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] inq  [NI][$];
  logic [31:0] outq [NO][$];
  logic [31:0] hold_m [NI];
  logic [NI-1:0] udf_m;
  logic [NO-1:0] ovf_m;

  logic [31:0]      obs_io_in;
  logic [NI-1:0]    obs_s_ready;
  logic [NO-1:0]    obs_m_valid;
  logic [NO*NB-1:0] obs_m_data;
  logic [NI-1:0]    obs_udf;
  logic [NO-1:0]    obs_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_io_in();
    for (int k = 0; k < NI; k++)
      if (bus.req_in[k]) return (inq[k].size() > 0) ? inq[k][0] : hold_m[k];
    return 32'd0;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] sv, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] oe, input logic [31:0] o,
                       input logic [1:0] mr);
    bus.req_in  = req;
    bus.s_valid = sv;
    bus.s_data  = {d1, d0};
    bus.out_en  = oe;
    bus.io_out  = o;
    bus.m_ready = mr;
  endtask

  task automatic model_update();
    int  in_sz [NI];
    int  out_sz [NO];
    bit  popped;
    bit  found;
    if (rst) begin
      for (int k = 0; k < NI; k++) begin inq[k].delete(); hold_m[k] = '0; end
      for (int k = 0; k < NO; k++) outq[k].delete();
      udf_m = '0;
      ovf_m = '0;
    end else begin
      for (int k = 0; k < NI; k++) in_sz[k] = inq[k].size();
      for (int k = 0; k < NO; k++) out_sz[k] = outq[k].size();
      found = 1'b0;
      for (int k = 0; k < NI; k++) begin
        if (!found && bus.req_in[k]) begin
          found = 1'b1;
          if (in_sz[k] > 0) hold_m[k] = inq[k].pop_front();
          else udf_m[k] = 1'b1;
        end
      end
      for (int k = 0; k < NI; k++)
        if (bus.s_valid[k] && in_sz[k] < FD) inq[k].push_back(bus.s_data[k*NB +: NB]);
      for (int k = 0; k < NO; k++) begin
        popped = bus.m_ready[k] && out_sz[k] > 0;
        if (popped) void'(outq[k].pop_front());
        if (bus.out_en[k]) begin
          if (out_sz[k] < FD || popped) outq[k].push_back(bus.io_out);
          else ovf_m[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [NI-1:0] exp_rdy;
    logic [NO-1:0] exp_mv;
    @(negedge clk);
    obs_io_in   = bus.io_in;
    obs_s_ready = bus.s_ready;
    obs_m_valid = bus.m_valid;
    obs_m_data  = bus.m_data;
    obs_udf     = bus.underflow;
    obs_ovf     = bus.overflow;
    check("io_in", obs_io_in, exp_io_in());
    for (int k = 0; k < NI; k++) exp_rdy[k] = !rst && inq[k].size() < FD;
    check("s_ready", obs_s_ready, exp_rdy);
    for (int k = 0; k < NO; k++) exp_mv[k] = outq[k].size() > 0;
    check("m_valid", obs_m_valid, exp_mv);
    for (int k = 0; k < NO; k++)
      if (outq[k].size() > 0) check("m_data", obs_m_data[k*NB +: NB], outq[k][0]);
    check("underflow", obs_udf, udf_m);
    check("overflow", obs_ovf, ovf_m);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) hold_m[k] = '0;
    udf_m = '0;
    ovf_m = '0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    check("rst_s_ready_low", obs_s_ready, 2'b00);
    rst = 1'b0;
    cycle();
    check("idle_s_ready", obs_s_ready, 2'b11);
    check("idle_io_in", obs_io_in, 0);
    check("idle_m_valid", obs_m_valid, 2'b00);
    check("idle_flags", {obs_udf, obs_ovf}, 4'b0000);

    drive(0, 2'b01, 32'h5, 0, 0, 0, 0);          cycle();
    drive(0, 2'b01, 32'hFFFFFFFB, 0, 0, 0, 0);   cycle();
    drive(2'b01, 0, 0, 0, 0, 0, 0);              cycle();
    check("rd_pos5", obs_io_in, 32'h5);
    cycle();
    check("rd_neg5", obs_io_in, 32'hFFFFFFFB);
    cycle();
    check("rd_hold", obs_io_in, 32'hFFFFFFFB);
    drive(0, 0, 0, 0, 0, 0, 0);                  cycle();
    check("udf0_set", obs_udf, 2'b01);

    drive(0, 2'b11, 32'h11, 32'h22, 0, 0, 0);    cycle();
    drive(2'b11, 0, 0, 0, 0, 0, 0);              cycle();
    check("prio_ch0", obs_io_in, 32'h11);
    drive(2'b10, 0, 0, 0, 0, 0, 0);              cycle();
    check("ch1_kept", obs_io_in, 32'h22);
    drive(0, 0, 0, 0, 0, 0, 0);                  cycle();
    check("udf1_clear", obs_udf, 2'b01);

    for (int i = 0; i < FD; i++) begin
      drive(0, 2'b10, 0, 32'd100 + i, 0, 0, 0);  cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);                  cycle();
    check("full_not_ready", obs_s_ready[1], 1'b0);
    drive(2'b10, 2'b10, 0, 32'hBAD, 0, 0, 0);    cycle();
    check("full_read", obs_io_in, 32'd100);
    drive(0, 0, 0, 0, 0, 0, 0);                  cycle();
    check("ready_back", obs_s_ready[1], 1'b1);
    for (int i = 1; i < FD; i++) begin
      drive(2'b10, 0, 0, 0, 0, 0, 0);            cycle();
      check("drain_in1", obs_io_in, 32'd100 + i);
    end

    for (int i = 1; i <= FD + 1; i++) begin
      drive(0, 0, 0, 0, 2'b10, i, 0);            cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);                  cycle();
    check("ovf1_set", obs_ovf, 2'b10);
    for (int i = 1; i <= FD; i++) begin
      drive(0, 0, 0, 0, 0, 0, 2'b10);            cycle();
      check("drain_out1", obs_m_data[NB +: NB], i);
    end

    for (int i = 0; i < FD; i++) begin
      drive(0, 0, 0, 0, 2'b01, 32'd200 + i, 0);  cycle();
    end
    drive(0, 0, 0, 0, 2'b01, 32'h7FFFFFFF, 2'b01); cycle();
    for (int i = 0; i < FD; i++) begin
      drive(0, 0, 0, 0, 0, 0, 2'b01);            cycle();
    end
    check("last_word", obs_m_data[NB-1:0], 32'h7FFFFFFF);
    check("no_ovf0", obs_ovf, 2'b10);

    drive(0, 2'b11, 32'hA, 32'hB, 2'b11, 32'hC, 0);
    cycle(); cycle(); cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);                  cycle();
    rst = 1'b0;                                  cycle();
    check("midrst_m_valid", obs_m_valid, 2'b00);
    check("midrst_flags", {obs_udf, obs_ovf}, 4'b0000);
    check("midrst_ready", obs_s_ready, 2'b11);
    drive(2'b01, 0, 0, 0, 0, 0, 0);              cycle();
    check("midrst_hold0", obs_io_in, 0);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) drive(0, 0, 0, 0, 0, 0, 0);
      else drive(2'($urandom), 2'($urandom), $urandom, $urandom,
                 2'($urandom_range(0, 3) == 0 ? $urandom : 0), $urandom, 2'($urandom));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ssf_io_bridge.md
Name: ssf_io_bridge

Overview:
- Responder end of the processor port protocol: serves `req_in` read strobes and `out_en` write strobes issued by a `proc_fx` core.
- Input side: per-channel FIFOs buffer samples from external valid/ready sources and deliver them on the core's input bus.
- Output side: per-channel FIFOs capture core writes and stream them out over valid/ready.
- Sits beside the `ssf` top level, replacing ad-hoc glue between ADC/DAC streams and the core.

Parameters:
- NUBITS, 32, data word width (matches core).
- NUIOIN, 2, number of input channels (width of `req_in`).
- NUIOOU, 2, number of output channels (width of `out_en`).
- FDEPTH, 8, entries per channel FIFO; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- io_in  output  NUBITS  data to core input port (signed).
- req_in  input  NUIOIN  core read strobes, one bit per input channel.
- io_out  input  NUBITS  data from core output port (signed).
- out_en  input  NUIOOU  core write strobes, one bit per output channel.
- s_data  input  NUIOIN*NUBITS  source samples; channel k occupies bits [k*NUBITS +: NUBITS].
- s_valid  input  NUIOIN  source valid per channel.
- s_ready  output  NUIOIN  bridge ready per channel.
- m_data  output  NUIOOU*NUBITS  sink samples, same packing as `s_data`.
- m_valid  output  NUIOOU  sink valid per channel.
- m_ready  input  NUIOOU  sink ready per channel.
- underflow  output  NUIOIN  sticky: core read an empty input channel.
- overflow  output  NUIOOU  sticky: core wrote a full output channel.

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset clears all FIFOs (pointers and counts) and all hold registers.
- Reset values: `io_in`=0, `s_ready`=0 while `rst` is high, `m_valid`=0, `m_data`=0, `underflow`=0, `overflow`=0.
- Reset asserted mid-operation discards all buffered data. No partial transfer survives.
- Input push: on an edge with `s_valid[k]` and `s_ready[k]`, write `s_data` slice k into input FIFO k.
  - `s_ready[k]` = not full.
  - A full FIFO refuses the push even if a pop occurs in the same cycle.
- Input read selection: the core cannot stall, so `io_in` is combinational in the `req_in` cycle.
  - Selected channel = lowest set bit of `req_in`. Any other set bits are ignored and do not pop.
  - `req_in`==0: `io_in`=0.
  - Selected channel non-empty: `io_in` = FIFO head. FIFO pops at the closing edge, and the hold register k takes that head.
  - Selected channel empty: `io_in` = hold register k (last delivered value, 0 after reset). `underflow[k]` sets at the edge. No pop.
- Input corner cases:
  - Push and read in the same cycle on an empty FIFO counts as underflow; there is no fall-through.
  - Latency from source to core: a sample accepted at edge N is readable from cycle N+1.
- Output write: on an edge with `out_en[k]`, push `io_out` into output FIFO k.
  - Multiple `out_en` bits set: every flagged channel captures the same `io_out`.
  - FIFO k full with no pop in that cycle: the word is dropped and `overflow[k]` sets.
  - FIFO k full with a pop (`m_valid[k]` and `m_ready[k]`) in the same cycle: the push is accepted and the count is unchanged.
- Output stream: `m_valid[k]` = not empty; `m_data` slice k = head. Pop on `m_valid[k]` and `m_ready[k]`.
  - Latency: a core write at edge N appears on `m_data` at cycle N+1 when the FIFO was empty.
- Sticky flags clear only on `rst`.
- Pointers wrap modulo FDEPTH. Count range is 0..FDEPTH, so the count needs log2(FDEPTH)+1 bits.

Optional Feature:
- Macro: `SSF_IO_BRIDGE_COUNT_EN`.
- Defined: adds output `xfer_cnt` of width (NUIOIN+NUIOOU)*16.
  - One 16-bit wrapping counter per channel. Input channels occupy the low slices, output channels the high slices.
  - Counters increment on successful core reads (pops) and accepted core writes.
  - Underflow reads and dropped writes are not counted. Counters reset to 0.
- Undefined: port and counters absent. All other behaviour is identical.

Decomposition:
- Package `ssf_io_pkg`:
  - default constants NUBITS=32 and FDEPTH=8;
  - function clog2;
  - function `lowest_set` (one-hot priority select).
- Sub-module `ssf_sync_fifo` (parameters NUBITS, FDEPTH):
  - ports: push, push_data, pop, head, full, empty, and the `force_push_on_pop` option used by the output side.
  - Instantiated NUIOIN+NUIOOU times via generate.

Test Plan:
- Reset then idle: `io_in`=0, `s_ready`=2'b11 one cycle after `rst` drops, `m_valid`=0, flags 0.
- Push 0x00000005 and 0xFFFFFFFB on ch0 → `req_in`=01 on two later cycles returns 5 then -5. Third read returns -5 (hold) and sets `underflow[0]`.
- `req_in`=11 with ch0=0x11 and ch1=0x22 buffered → `io_in`=0x11, ch0 pops, ch1 count unchanged.
- Fill ch1 with 8 words → `s_ready[1]`=0. Next read restores `s_ready[1]`=1 one cycle later.
- `m_ready`=0, 9 writes `out_en`=10 with values 1..9 → `overflow[1]`=1. Draining `m_data` ch1 yields 1..8.
- Output FIFO full, `m_ready[0]`=1 and `out_en`=01 with `io_out`=0x7FFFFFFF in the same cycle → no overflow, and 0x7FFFFFFF is the last drained word.
